// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-line instruction cache between the
// fetch stage and the byte-serial memory controller's instruction port.
// Ports: clk_in/rst_in (sync, active-high); jump_or_not_in flush;
//   if_req_in/if_pc_in -> if_inst_out/if_valid_out (fetch side);
//   inst_enable_out/inst_address_out <- inst_data_in/inst_enable_in,
//   inst_busy_in (controller side, busy is informational only).
// Build option: define ICACHE_ARRAY_EN to instantiate the tag/data/valid
//   arrays; without it every lookup misses and nothing is filled.
module icache #(
  parameter int INDEX_BITS = 7,
  parameter int TAG_BITS   = 32 - INDEX_BITS - 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        jump_or_not_in,
  input  logic        if_req_in,
  input  logic [31:0] if_pc_in,
  output logic [31:0] if_inst_out,
  output logic        if_valid_out,
  output logic        inst_enable_out,
  output logic [31:0] inst_address_out,
  input  logic [31:0] inst_data_in,
  input  logic        inst_enable_in,
  input  logic        inst_busy_in
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic        req_q;
  logic [31:0] addr_q;
  logic        hit;
  logic [31:0] rd_data;
  logic        fill_en;

  // A fill happens whenever the controller answers during MISS, even
  // under a jump: the word is correct for the latched address.
  assign fill_en = (state == MISS) && inst_enable_in;

  // Drop the request in the response cycle so the controller does not
  // start a second fetch.
  assign inst_enable_out  = req_q & ~inst_enable_in;
  assign inst_address_out = addr_q;

  logic unused_ok;
  assign unused_ok = ^{inst_busy_in, if_pc_in[1:0]};

`ifdef ICACHE_ARRAY_EN
  localparam int LINES = 2 ** INDEX_BITS;

  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [31:0]           data_mem [LINES];
  logic [LINES-1:0]      valid_q;
  logic [INDEX_BITS-1:0] rd_idx;
  logic [INDEX_BITS-1:0] wr_idx;
  logic [TAG_BITS-1:0]   rd_tag;

  assign rd_idx  = if_pc_in[INDEX_BITS+1:2];
  assign rd_tag  = if_pc_in[31:INDEX_BITS+2];
  assign wr_idx  = addr_q[INDEX_BITS+1:2];
  assign rd_data = data_mem[rd_idx];
  assign hit     = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && fill_en) begin
      tag_mem[wr_idx]  <= addr_q[31:INDEX_BITS+2];
      data_mem[wr_idx] <= inst_data_in;
    end
  end
`else
  assign hit     = 1'b0;
  assign rd_data = 32'h0;

  logic unused_fill;
  assign unused_fill = fill_en;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      req_q        <= 1'b0;
      addr_q       <= 32'h0;
      if_valid_out <= 1'b0;
      if_inst_out  <= 32'h0;
    end else begin
      if_valid_out <= 1'b0;
      if (jump_or_not_in) begin
        state <= IDLE;
        req_q <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (if_req_in) begin
              if (hit) begin
                if_inst_out  <= rd_data;
                if_valid_out <= 1'b1;
                state        <= RESP;
              end else begin
                addr_q <= {if_pc_in[31:2], 2'b00};
                req_q  <= 1'b1;
                state  <= MISS;
              end
            end
          end
          MISS: begin
            if (inst_enable_in) begin
              if_inst_out  <= inst_data_in;
              if_valid_out <= 1'b1;
              req_q        <= 1'b0;
              state        <= RESP;
            end
          end
          RESP: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed checks of icache hit, miss, conflict, jump,
// busy-controller and reset behaviour with a hand-driven controller.
module tb_icache;

  logic        clk_in;
  logic        rst_in;
  logic        jump_or_not_in;
  logic        if_req_in;
  logic [31:0] if_pc_in;
  logic [31:0] if_inst_out;
  logic        if_valid_out;
  logic        inst_enable_out;
  logic [31:0] inst_address_out;
  logic [31:0] inst_data_in;
  logic        inst_enable_in;
  logic        inst_busy_in;

  int n_tests = 0;
  int n_fail  = 0;

  icache dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .jump_or_not_in   (jump_or_not_in),
    .if_req_in        (if_req_in),
    .if_pc_in         (if_pc_in),
    .if_inst_out      (if_inst_out),
    .if_valid_out     (if_valid_out),
    .inst_enable_out  (inst_enable_out),
    .inst_address_out (inst_address_out),
    .inst_data_in     (inst_data_in),
    .inst_enable_in   (inst_enable_in),
    .inst_busy_in     (inst_busy_in)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_check(input string tag);
    chk({tag, "_valid"}, {31'b0, if_valid_out}, 32'd0);
    chk({tag, "_en"}, {31'b0, inst_enable_out}, 32'd0);
  endtask

  // Miss: request held for lat cycles, then a one-cycle response pulse.
  task automatic fetch_miss(input logic [31:0] pc,
                            input logic [31:0] data,
                            input int lat);
    @(negedge clk_in);
    if_req_in = 1'b1;
    if_pc_in  = pc;
    @(negedge clk_in);
    for (int i = 0; i < lat; i++) begin
      chk("req_en", {31'b0, inst_enable_out}, 32'd1);
      chk("req_addr", inst_address_out, {pc[31:2], 2'b00});
      chk("early_valid", {31'b0, if_valid_out}, 32'd0);
      @(negedge clk_in);
    end
    inst_enable_in = 1'b1;
    inst_data_in   = data;
    #1;
    chk("req_drop", {31'b0, inst_enable_out}, 32'd0);
    @(negedge clk_in);
    inst_enable_in = 1'b0;
    inst_data_in   = 32'h0;
    if_req_in      = 1'b0;
    chk("miss_valid", {31'b0, if_valid_out}, 32'd1);
    chk("miss_data", if_inst_out, data);
    chk("miss_en", {31'b0, inst_enable_out}, 32'd0);
    @(negedge clk_in);
    idle_check("miss_after");
  endtask

  task automatic fetch_hit(input logic [31:0] pc,
                           input logic [31:0] data);
    @(negedge clk_in);
    if_req_in = 1'b1;
    if_pc_in  = pc;
    @(negedge clk_in);
    if_req_in = 1'b0;
    chk("hit_valid", {31'b0, if_valid_out}, 32'd1);
    chk("hit_data", if_inst_out, data);
    chk("hit_en", {31'b0, inst_enable_out}, 32'd0);
    @(negedge clk_in);
    idle_check("hit_after");
  endtask

  // A previously filled line: hit with arrays, full miss without.
  task automatic fetch_cached(input logic [31:0] pc,
                              input logic [31:0] data);
`ifdef ICACHE_ARRAY_EN
    fetch_hit(pc, data);
`else
    fetch_miss(pc, data, 5);
`endif
  endtask

  initial begin
    rst_in         = 1'b1;
    jump_or_not_in = 1'b0;
    if_req_in      = 1'b0;
    if_pc_in       = 32'h0;
    inst_data_in   = 32'h0;
    inst_enable_in = 1'b0;
    inst_busy_in   = 1'b0;
    repeat (2) @(negedge clk_in);
    chk("rst_valid", {31'b0, if_valid_out}, 32'd0);
    chk("rst_inst", if_inst_out, 32'h0);
    chk("rst_en", {31'b0, inst_enable_out}, 32'd0);
    chk("rst_addr", inst_address_out, 32'h0);
    rst_in = 1'b0;

    fetch_miss(32'h0000_0000, 32'h0000_0013, 5);
    fetch_cached(32'h0000_0000, 32'h0000_0013);

    fetch_miss(32'h0000_0200, 32'h1111_1111, 5);
    fetch_miss(32'h0000_0000, 32'h0000_0013, 5);

    // Jump two cycles into a miss on 0x40.
    @(negedge clk_in);
    if_req_in = 1'b1;
    if_pc_in  = 32'h0000_0040;
    @(negedge clk_in);
    chk("jmp_en0", {31'b0, inst_enable_out}, 32'd1);
    @(negedge clk_in);
    chk("jmp_en1", {31'b0, inst_enable_out}, 32'd1);
    jump_or_not_in = 1'b1;
    if_req_in      = 1'b0;
    @(negedge clk_in);
    jump_or_not_in = 1'b0;
    idle_check("jmp_next");
    @(negedge clk_in);
    idle_check("jmp_next2");
    inst_enable_in = 1'b1;
    inst_data_in   = 32'h0BAD_0BAD;
    @(negedge clk_in);
    inst_enable_in = 1'b0;
    inst_data_in   = 32'h0;
    idle_check("stray");
    @(negedge clk_in);
    idle_check("stray2");
    fetch_miss(32'h0000_0040, 32'h5555_0040, 5);

    // Controller held busy by a data access: 10 extra cycles.
    inst_busy_in = 1'b1;
    fetch_miss(32'h0000_0080, 32'hCAFE_F00D, 15);
    inst_busy_in = 1'b0;
    @(negedge clk_in);
    idle_check("busy_after");

    // Jump in the same cycle as the response: fill, no response.
    @(negedge clk_in);
    if_req_in = 1'b1;
    if_pc_in  = 32'h0000_00C0;
    @(negedge clk_in);
    for (int i = 0; i < 5; i++) begin
      chk("jf_en", {31'b0, inst_enable_out}, 32'd1);
      chk("jf_addr", inst_address_out, 32'h0000_00C0);
      @(negedge clk_in);
    end
    inst_enable_in = 1'b1;
    inst_data_in   = 32'hDEAD_BEEF;
    jump_or_not_in = 1'b1;
    if_req_in      = 1'b0;
    @(negedge clk_in);
    inst_enable_in = 1'b0;
    inst_data_in   = 32'h0;
    jump_or_not_in = 1'b0;
    idle_check("jf_next");
    @(negedge clk_in);
    idle_check("jf_next2");
    fetch_cached(32'h0000_00C0, 32'hDEAD_BEEF);

    // Reset in the middle of a miss on 0x100.
    @(negedge clk_in);
    if_req_in = 1'b1;
    if_pc_in  = 32'h0000_0100;
    @(negedge clk_in);
    @(negedge clk_in);
    chk("rm_en", {31'b0, inst_enable_out}, 32'd1);
    rst_in    = 1'b1;
    if_req_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
    chk("rm_en_drop", {31'b0, inst_enable_out}, 32'd0);
    chk("rm_addr", inst_address_out, 32'h0);
    chk("rm_inst", if_inst_out, 32'h0);
    chk("rm_valid", {31'b0, if_valid_out}, 32'd0);
    // Valid bits were cleared, so a formerly filled line misses.
    fetch_miss(32'h0000_0000, 32'h0000_0013, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
